// File: rtl/snax_hwpe_periph_arb.sv
// Round-robin arbiter sharing one HWPE peripheral port among NumReq requesters, one transaction in flight.
// Optional read-response timeout enabled by defining SNAX_HWPE_ARB_TIMEOUT_EN.
module snax_hwpe_periph_arb #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned IdWidth       = 5,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                s_req_i,
    output logic [NumReq-1:0]                s_gnt_o,
    input  logic [NumReq-1:0][31:0]          s_add_i,
    input  logic [NumReq-1:0]                s_wen_i,
    input  logic [NumReq-1:0][3:0]           s_be_i,
    input  logic [NumReq-1:0][31:0]          s_data_i,
    input  logic [NumReq-1:0][IdWidth-1:0]   s_id_i,
    output logic [NumReq-1:0]                s_r_valid_o,
    output logic [31:0]                      s_r_data_o,
    output logic [IdWidth-1:0]               s_r_id_o,
    output logic                             m_req_o,
    output logic [31:0]                      m_add_o,
    output logic                             m_wen_o,
    output logic [3:0]                       m_be_o,
    output logic [31:0]                      m_data_o,
    output logic [IdWidth-1:0]               m_id_o,
    input  logic                             m_gnt_i,
    input  logic                             m_r_valid_i,
    input  logic [31:0]                      m_r_data_i,
    input  logic [IdWidth-1:0]               m_r_id_i,
    output logic                             busy_o,
    output logic                             timeout_o
);

    localparam int unsigned PtrW = $clog2(NumReq);

    if (NumReq < 2 || NumReq > 8 || TimeoutCycles == 0) begin : g_bad_params
        $error("snax_hwpe_periph_arb: NumReq must be 2..8 and TimeoutCycles nonzero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] win_q, win_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] pick;

`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdWidth-1:0] rid_q, rid_d;
`endif

    // First requester at or after ptr+1 (mod NumReq); descending scan so the nearest one wins.
    always_comb begin
        pick = '0;
        for (int unsigned i = NumReq; i >= 1; i--) begin
            if (s_req_i[PtrW'((32'(ptr_q) + i) % NumReq)]) begin
                pick = PtrW'((32'(ptr_q) + i) % NumReq);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= PtrW'(NumReq - 1);
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            rid_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            rid_q   <= rid_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        ptr_d       = ptr_q;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rid_d       = rid_q;
`endif
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        s_r_data_o  = '0;
        s_r_id_o    = '0;
        m_req_o     = 1'b0;
        m_add_o     = '0;
        m_wen_o     = 1'b0;
        m_be_o      = '0;
        m_data_o    = '0;
        m_id_o      = '0;
        timeout_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|s_req_i) begin
                    win_d   = pick;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
                    rid_d   = s_id_i[pick];
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                m_req_o          = s_req_i[win_q];
                m_add_o          = s_add_i[win_q];
                m_wen_o          = s_wen_i[win_q];
                m_be_o           = s_be_i[win_q];
                m_data_o         = s_data_i[win_q];
                m_id_o           = s_id_i[win_q];
                s_gnt_o[win_q]   = m_gnt_i;
                // A withdrawn request abandons the slot without advancing fairness.
                if (!s_req_i[win_q]) begin
                    state_d = IDLE;
                end else if (m_gnt_i) begin
                    if (s_wen_i[win_q]) begin
                        state_d = RESP;
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        ptr_d   = win_q;
                    end
                end
            end
            RESP: begin
                s_r_valid_o[win_q] = m_r_valid_i;
                s_r_data_o         = m_r_data_i;
                s_r_id_o           = m_r_id_i;
                if (m_r_valid_i) begin
                    state_d = IDLE;
                    ptr_d   = win_q;
                end
`ifdef SNAX_HWPE_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    s_r_valid_o[win_q] = 1'b1;
                    s_r_data_o         = 32'hDEADBEEF;
                    s_r_id_o           = rid_q;
                    timeout_o          = 1'b1;
                    state_d            = IDLE;
                    ptr_d              = win_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: doc/snax_hwpe_periph_arb.md
# snax_hwpe_periph_arb

Round-robin arbiter that shares one HWPE peripheral (register-file) port among `NumReq` requesters, e.g. several Snitch-side CSR/accelerator controllers driving a single SNAX MAC HWPE. It sits between the requesters' 32-bit periph-style masters and the accelerator's `hwpe_ctrl_intf_periph` slave. It allows exactly one transaction in flight, routes read responses back to the issuing requester, and can optionally time out a lost read response.

## Interface
- `NumReq`, 2: number of requesters, range 2..8.
- `IdWidth`, 5: width of the transaction ID.
- `TimeoutCycles`, 255: read-response timeout in cycles; used only with the timeout macro.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; synchronous and active-low.
- `s_req_i`  in  NumReq  per-requester request; held high until the matching `s_gnt_o`.
- `s_gnt_o`  out  NumReq  per-requester grant.
- `s_add_i`  in  NumReq×32  byte address.
- `s_wen_i`  in  NumReq  1 = read, 0 = write.
- `s_be_i`  in  NumReq×4  byte enable.
- `s_data_i`  in  NumReq×32  write data.
- `s_id_i`  in  NumReq×IdWidth  transaction ID.
- `s_r_valid_o`  out  NumReq  per-requester read-response valid.
- `s_r_data_o`  out  32  read data, shared by all requesters.
- `s_r_id_o`  out  IdWidth  read ID, shared by all requesters.
- `m_req_o`, `m_add_o`[32], `m_wen_o`, `m_be_o`[4], `m_data_o`[32], `m_id_o`[IdWidth]  out  request to the HWPE port.
- `m_gnt_i`  in  1  HWPE grant.
- `m_r_valid_i`  in  1  HWPE read-response valid.
- `m_r_data_i`  in  32  HWPE read data.
- `m_r_id_i`  in  IdWidth  HWPE read ID.
- `busy_o`  out  1  high in state REQ or RESP.
- `timeout_o`  out  1  one-cycle pulse when a read times out.

## Operation
- FSM states: IDLE, REQ, RESP.
- Registers: `win` (winner index), `ptr` (last served requester, round-robin base), `rid_q` (latched ID), `cnt` (timeout counter).
- **IDLE**
  - If any `s_req_i` is high, the winner is the first set bit searching from `ptr+1` upward, wrapping modulo NumReq.
  - Register the winner in `win` and the winner's `s_id_i` in `rid_q`; go to REQ.
  - With no request pending, stay in IDLE.
- **REQ**
  - `m_req_o = s_req_i[win]`; all other `m_*` payload outputs are a combinational mux of `s_*[win]`.
  - `s_gnt_o[win] = m_gnt_i`; every other `s_gnt_o` bit is 0.
  - On `m_gnt_i` with a write: go to IDLE and set `ptr <= win`.
  - On `m_gnt_i` with a read: go to RESP and clear `cnt`.
  - If `s_req_i[win]` drops before the grant: go to IDLE; `ptr` is unchanged.
- **RESP**
  - `s_r_valid_o[win] = m_r_valid_i`; `s_r_data_o = m_r_data_i`; `s_r_id_o = m_r_id_i`.
  - On `m_r_valid_i`: go to IDLE and set `ptr <= win`.
- Outside RESP: `s_r_valid_o = 0`, `s_r_data_o = 0`, `s_r_id_o = 0`.
- `m_r_valid_i` arriving outside RESP is ignored.
- `m_*` payload outputs are 0 outside REQ.

## Timing
- Reset values:
  - Registers: state = IDLE, `ptr` = NumReq-1 (requester 0 wins first), `win` = 0, `rid_q` = 0, `cnt` = 0.
  - Outputs: all outputs are 0.
- A reset asserted mid-transaction aborts the transaction; any later HWPE response is ignored.
- Arbitration latency: `s_req_i` rising in cycle t gives `m_req_o` high in cycle t+1.
- A write with immediate grant occupies 2 cycles (IDLE + REQ).
- Peak throughput is 1 transaction per 2 cycles; IDLE is always visited between transactions.
- A read response is forwarded combinationally in the same cycle as `m_r_valid_i`.
- Fairness: a continuously requesting requester waits at most NumReq-1 completed transactions.

## Configuration
- `SNAX_HWPE_ARB_TIMEOUT_EN` defined:
  - In RESP, `cnt` increments each cycle.
  - When `cnt == TimeoutCycles-1` and `m_r_valid_i` is low, the arbiter returns an error response:
    - `s_r_valid_o[win] = 1`, `s_r_data_o = 32'hDEADBEEF`, `s_r_id_o = rid_q`;
    - `timeout_o` pulses for that cycle;
    - go to IDLE and set `ptr <= win`.
  - A real response in that same cycle takes priority; no timeout is raised.
  - A late real response after a timeout is ignored.
- `SNAX_HWPE_ARB_TIMEOUT_EN` undefined:
  - RESP waits indefinitely for `m_r_valid_i`.
  - `cnt` is not implemented and `timeout_o` is tied to 0.

## Test plan
- Single write from requester 0 (add 0x40, data 0x1234, `m_gnt_i` tied 1): `m_req_o` is high exactly one cycle after `s_req_i[0]`; `s_gnt_o[0]` pulses in that cycle; `ptr` becomes 0.
- Read from requester 1 with response after 3 cycles (data 0xCAFE, id 7): `s_r_valid_o[1]` is high for 1 cycle carrying 0xCAFE/id 7; `s_r_valid_o[0]` stays 0.
- All 3 requesters (NumReq=3) holding requests continuously, writes only: grant order is 0,1,2,0,1,2.
- Requester 1 drops `s_req_i` while in REQ with `m_gnt_i` held low: `m_req_o` falls in the same cycle; FSM returns to IDLE; `ptr` is unchanged.
- Timeout (macro on, TimeoutCycles=4, no response): error response 0xDEADBEEF with the latched ID and a `timeout_o` pulse 4 cycles after the read grant; a later stray `m_r_valid_i` is ignored.
- `rst_ni` low for one cycle while in RESP: the next cycle is IDLE with all outputs 0 and `ptr` = NumReq-1; requester 0 wins next.
